// File: rtl/mem_port_arbiter_if.sv
// Request/response signals of the fetch and data requesters plus the shared
// 64-bit memory port, as seen by mem_port_arbiter (slave) and its peers (master).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [7:0]        d_wmask;
  logic [63:0]       d_wdata;
  logic              d_ready;
  logic [63:0]       d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_addr, d_we, d_wmask, d_wdata,
    input  mem_rdata, mem_ack,
    output if_ready, if_rdata, if_err,
    output d_ready, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_addr, d_we, d_wmask, d_wdata,
    output mem_rdata, mem_ack,
    input  if_ready, if_rdata, if_err,
    input  d_ready, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single 64-bit memory port between instruction fetch and the
// MEM-stage data requester, with IF anti-starvation and a hung-access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int MAX_D_GRANTS = 4,
  parameter int TIMEOUT      = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic       {OWN_IF, OWN_D}     owner_t;

  localparam logic [3:0] MAX_G = 4'(MAX_D_GRANTS);
  localparam logic [7:0] TMO   = 8'(TIMEOUT);

  function automatic logic [31:0] word_sel(input logic hi, input logic [63:0] dw);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [3:0]          gcnt_q, gcnt_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic [ADDR_W-1:2]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [7:0]          wmask_q, wmask_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [63:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                d_wins;
  logic                in_issue;
  logic                in_resp;
  logic                unused_addr_lsbs;

  // Requesters present word/doubleword addresses; the byte offset is never needed.
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gcnt_d  = gcnt_q;
    tcnt_d  = tcnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    d_wins  = bus.d_req && (!bus.if_req || (gcnt_q != MAX_G));

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (d_wins) begin
          owner_d = OWN_D;
          addr_d  = bus.d_addr[ADDR_W-1:2];
          we_d    = bus.d_we;
          wmask_d = bus.d_we ? bus.d_wmask : 8'h00;
          wdata_d = bus.d_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          gcnt_d  = bus.if_req ? gcnt_q + 4'd1 : 4'd0;
          // A store that enables no bytes has nothing to send to memory.
          state_d = (bus.d_we && (bus.d_wmask == 8'h00)) ? RESP : ISSUE;
        end else if (bus.if_req) begin
          owner_d = OWN_IF;
          addr_d  = bus.if_addr[ADDR_W-1:2];
          we_d    = 1'b0;
          wmask_d = 8'h00;
          wdata_d = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          gcnt_d  = 4'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else if (tcnt_q + 8'd1 == TMO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d  = tcnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      gcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  // Latched access fields; every output that exposes them is gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wmask_q <= wmask_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign in_issue = (state_q == ISSUE);
  assign in_resp  = (state_q == RESP);

  assign bus.mem_req   = in_issue;
  assign bus.mem_we    = in_issue && we_q;
  assign bus.mem_addr  = in_issue ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign bus.mem_wmask = in_issue ? wmask_q : 8'h00;
  assign bus.mem_wdata = in_issue ? wdata_q : 64'h0;

  assign bus.if_ready  = in_resp && (owner_q == OWN_IF);
  assign bus.if_err    = bus.if_ready && err_q;
  assign bus.if_rdata  = bus.if_ready ? word_sel(addr_q[2], rdata_q) : 32'h0;

  assign bus.d_ready   = in_resp && (owner_q == OWN_D);
  assign bus.d_err     = bus.d_ready && err_q;
  assign bus.d_rdata   = (bus.d_ready && !we_q) ? rdata_q : 64'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Vector table plus scoreboard bench for mem_port_arbiter with a behavioural
// variable-latency memory model.
module tb_mem_port_arbiter;
  localparam int ADDR_W       = 32;
  localparam int MAX_D_GRANTS = 4;
  localparam int TIMEOUT      = 16;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .MAX_D_GRANTS(MAX_D_GRANTS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        is_d;
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } mem_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          we;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    int          lat;      // -1: memory never acknowledges
    bit          mem_exp;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wmask;
    logic [63:0] rdata;
    bit          err;
    int          rlat;     // cycles from driving req to the ready pulse
  } vec_t;

  int checks = 0;
  int errors = 0;
  rsp_t exp_rsp_q[$];
  mem_t exp_mem_q[$];
  logic [63:0] mem_a [logic [31:0]];
  int mem_lat   = 0;
  int mreq_run  = 0;
  int last_run  = 0;
  int n_ready   = 0;
  int spur_req  = 0;
  int spur_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  function automatic logic [63:0] mem_rd(input logic [31:0] a);
    return mem_a.exists(a) ? mem_a[a] : 64'h0;
  endfunction

  // One clock: response scoreboard, memory-port scoreboard and memory model.
  task automatic tick();
    rsp_t        r;
    mem_t        m;
    logic [63:0] bm;
    @(posedge clk);
    #1;
    if (bus.if_ready || bus.d_ready) begin
      n_ready++;
      chk("single_ready", 64'(bus.if_ready & bus.d_ready), 64'd0);
      if (exp_rsp_q.size() == 0) begin
        fail_now("unexpected_ready", {62'd0, bus.if_ready, bus.d_ready});
      end else begin
        r = exp_rsp_q.pop_front();
        chk("ready_owner_is_d", 64'(bus.d_ready), 64'(r.is_d));
        if (r.is_d) begin
          chk("d_rdata", bus.d_rdata, r.rdata);
          chk("d_err", 64'(bus.d_err), 64'(r.err));
        end else begin
          chk("if_rdata", 64'(bus.if_rdata), r.rdata);
          chk("if_err", 64'(bus.if_err), 64'(r.err));
        end
      end
    end
    if (bus.mem_req) begin
      if (mreq_run == 0) begin
        if (exp_mem_q.size() == 0) begin
          fail_now("unexpected_mem_req", 64'(bus.mem_addr));
        end else begin
          m = exp_mem_q.pop_front();
          chk("mem_addr", 64'(bus.mem_addr), 64'(m.addr));
          chk("mem_we", 64'(bus.mem_we), 64'(m.we));
          chk("mem_wmask", 64'(bus.mem_wmask), 64'(m.wmask));
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
        end
      end
      if (mem_lat >= 0 && mreq_run == mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_rd(bus.mem_addr);
        if (bus.mem_we) begin
          for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{bus.mem_wmask[i]}};
          mem_a[bus.mem_addr] = (mem_rd(bus.mem_addr) & ~bm) | (bus.mem_wdata & bm);
        end
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      mreq_run++;
    end else begin
      if (mreq_run != 0) last_run = mreq_run;
      mreq_run      = 0;
      bus.mem_ack   = (spur_req != spur_done);
      spur_done     = spur_req;
      bus.mem_rdata = 64'hFEED_FACE_FEED_FACE;
    end
  endtask

  function automatic vec_t mkv(bit is_d, logic [31:0] addr, bit we, logic [7:0] wmask,
                               logic [63:0] wdata, int lat, bit mem_exp, logic [31:0] mem_addr,
                               logic [7:0] mem_wmask, logic [63:0] rdata, bit err, int rlat);
    vec_t v;
    v.is_d = is_d;       v.addr = addr;         v.we = we;
    v.wmask = wmask;     v.wdata = wdata;       v.lat = lat;
    v.mem_exp = mem_exp; v.mem_addr = mem_addr; v.mem_wmask = mem_wmask;
    v.rdata = rdata;     v.err = err;           v.rlat = rlat;
    return v;
  endfunction

  task automatic run_vec(input string name, input vec_t v);
    int n0;
    int cyc;
    mem_lat  = v.lat;
    last_run = 0;
    exp_rsp_q.push_back('{is_d: v.is_d, rdata: v.rdata, err: v.err});
    if (v.mem_exp)
      exp_mem_q.push_back('{addr: v.mem_addr, we: v.is_d & v.we, wmask: v.mem_wmask, wdata: v.wdata});
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_addr = v.addr; bus.d_we = v.we;
      bus.d_wmask = v.wmask; bus.d_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    n0  = n_ready;
    cyc = 0;
    while (n_ready == n0 && cyc < 40) begin
      tick();
      cyc++;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    if (n_ready == n0) fail_now({name, "_ready_timeout"}, 64'(cyc));
    else chk({name, "_latency"}, 64'(cyc), 64'(v.rlat));
    if (v.mem_exp) chk({name, "_mem_req_cycles"}, 64'(last_run), 64'(v.lat < 0 ? TIMEOUT : v.lat + 1));
    tick();
  endtask

  vec_t vecs[11];

  initial begin
    int n0;
    int cyc;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0;  bus.d_addr = '0; bus.d_we = 1'b0; bus.d_wmask = '0; bus.d_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    mem_a[32'h40]  = 64'h1122334455667788;
    mem_a[32'h100] = 64'hAAAABBBB_CCCCDDDD;

    //               is_d addr       we mask   wdata                  lat mem mem_addr   mmask  rdata                  err rlat
    vecs[0]  = mkv(1, 32'h40,  0, 8'hFF, 64'h0,                  1, 1, 32'h40,  8'h00, 64'h1122334455667788, 0, 3);
    vecs[1]  = mkv(0, 32'h104, 0, 8'h00, 64'h0,                  0, 1, 32'h100, 8'h00, 64'h00000000AAAABBBB, 0, 2);
    vecs[2]  = mkv(0, 32'h100, 0, 8'h00, 64'h0,                  2, 1, 32'h100, 8'h00, 64'h00000000CCCCDDDD, 0, 4);
    vecs[3]  = mkv(1, 32'h80,  1, 8'h0F, 64'h00000000DEADBEEF,   1, 1, 32'h80,  8'h0F, 64'h0,                0, 3);
    vecs[4]  = mkv(1, 32'h80,  0, 8'h00, 64'h0,                  0, 1, 32'h80,  8'h00, 64'h00000000DEADBEEF, 0, 2);
    vecs[5]  = mkv(1, 32'h8C,  1, 8'hF0, 64'h12345678_00000000,  0, 1, 32'h88,  8'hF0, 64'h0,                0, 2);
    vecs[6]  = mkv(0, 32'h8C,  0, 8'h00, 64'h0,                  1, 1, 32'h88,  8'h00, 64'h0000000012345678, 0, 3);
    vecs[7]  = mkv(1, 32'h40,  1, 8'h00, 64'hFFFFFFFFFFFFFFFF,   0, 0, 32'h0,   8'h00, 64'h0,                0, 1);
    vecs[8]  = mkv(1, 32'h47,  0, 8'h00, 64'h0,                  3, 1, 32'h40,  8'h00, 64'h1122334455667788, 0, 5);
    vecs[9]  = mkv(1, 32'h40,  0, 8'h00, 64'h0,                 -1, 1, 32'h40,  8'h00, 64'h0,                1, 17);
    vecs[10] = mkv(0, 32'h104, 0, 8'h00, 64'h0,                 -1, 1, 32'h100, 8'h00, 64'h0,                1, 17);

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ctrl_outputs", {58'd0, bus.if_ready, bus.if_err, bus.d_ready, bus.d_err, bus.mem_req, bus.mem_we}, 64'd0);
    chk("rst_if_rdata", 64'(bus.if_rdata), 64'd0);
    chk("rst_d_rdata", bus.d_rdata, 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Late acknowledge after a timed-out access must not produce a response.
    run_vec("hang_again", mkv(1, 32'h40, 0, 8'h00, 64'h0, -1, 1, 32'h40, 8'h00, 64'h0, 1, 17));
    spur_req++;
    n0 = n_ready;
    repeat (4) tick();
    chk("late_ack_no_ready", 64'(n_ready - n0), 64'd0);
    chk("late_ack_no_mem_req", 64'(bus.mem_req), 64'd0);

    // Both requesters held: four data grants, then a forced fetch, twice over.
    mem_lat = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        exp_rsp_q.push_back('{is_d: 1'b0, rdata: 64'h00000000CCCCDDDD, err: 1'b0});
        exp_mem_q.push_back('{addr: 32'h100, we: 1'b0, wmask: 8'h00, wdata: 64'h0});
      end else begin
        exp_rsp_q.push_back('{is_d: 1'b1, rdata: 64'h1122334455667788, err: 1'b0});
        exp_mem_q.push_back('{addr: 32'h40, we: 1'b0, wmask: 8'h00, wdata: 64'h0});
      end
    end
    bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_we = 1'b0; bus.d_wmask = 8'h00;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    n0  = n_ready;
    cyc = 0;
    while (n_ready - n0 < 10 && cyc < 100) begin
      tick();
      cyc++;
    end
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    chk("fair_ready_count", 64'(n_ready - n0), 64'd10);
    chk("fair_cycles", 64'(cyc), 64'd29);
    repeat (2) tick();

    // Reset during an outstanding fetch.
    mem_lat = -1;
    exp_mem_q.push_back('{addr: 32'h100, we: 1'b0, wmask: 8'h00, wdata: 64'h0});
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    repeat (4) tick();
    chk("pre_rst_mem_req", 64'(bus.mem_req), 64'd1);
    rst = 1'b1;
    bus.if_req = 1'b0;
    n0 = n_ready;
    tick();
    chk("rst_mid_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mid_if_ready", 64'(bus.if_ready), 64'd0);
    rst = 1'b0;
    spur_req++;
    repeat (5) tick();
    chk("rst_mid_no_ready", 64'(n_ready - n0), 64'd0);
    run_vec("after_rst", mkv(0, 32'h104, 0, 8'h00, 64'h0, 0, 1, 32'h100, 8'h00, 64'h00000000AAAABBBB, 0, 2));

    chk("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);
    chk("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single shared 64-bit memory port between the instruction-fetch (IF) requester and the MEM-stage data requester.
- Data loads and stores are qualified by the decoder's mem_wr/wmask outputs. The block handles variable-latency memory acknowledges, forces IF a turn after a run of data grants, and aborts hung accesses on timeout.
- Sits between the IF/MEM pipeline stages and the memory model. Pipeline stages stall while their req is high and ready is low.

Parameters:
ADDR_W, 32, byte-address width of both requesters and the memory port
MAX_D_GRANTS, 4, consecutive data grants allowed while IF waits before IF is forced (1..15)
TIMEOUT, 16, cycles in ISSUE without mem_ack before abort (2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with stable if_addr until if_ready
if_addr  in  ADDR_W  fetch byte address (4-byte aligned)
if_ready  out  1  one-cycle pulse: fetch complete
if_rdata  out  32  fetched word, valid while if_ready=1
if_err  out  1  with if_ready: fetch timed out
d_req  in  1  data request; held with stable addr/wdata/we/wmask until d_ready
d_addr  in  ADDR_W  data byte address
d_we  in  1  1 = store, 0 = load
d_wmask  in  8  byte-enable for stores (bit i = byte i of the aligned doubleword)
d_wdata  in  64  store data, pre-positioned in the doubleword
d_ready  out  1  one-cycle pulse: data access complete
d_rdata  out  64  loaded doubleword, valid while d_ready=1
d_err  out  1  with d_ready: access timed out
mem_req  out  1  memory access request; held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  {addr[ADDR_W-1:3], 3'b000}
mem_wmask  out  8  byte-enables; 8'h00 on reads
mem_wdata  out  64  write data
mem_rdata  in  64  read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset: all outputs 0, state IDLE, grant counter 0, timeout counter 0.
- States: IDLE, ISSUE, RESP. The owner register holds IF or D.
- IDLE arbitration:
  - If only one request is high, grant it.
  - If both are high, grant D unless the grant counter equals MAX_D_GRANTS, in which case grant IF.
  - On a grant, latch addr/we/wmask/wdata/owner and go to ISSUE.
  - Grant counter: +1 on a D grant while if_req=1; cleared on any IF grant; cleared on a D grant while if_req=0.
- Zero-mask store (d_we=1, d_wmask=0) in IDLE: no memory access. Go directly to RESP with d_ready next cycle, d_err=0.
- ISSUE:
  - mem_req=1 with registered address/controls. An IF access drives mem_we=0 and mem_wmask=0.
  - On mem_ack: capture mem_rdata and go to RESP.
  - Timeout counter increments each ISSUE cycle without ack. When it reaches TIMEOUT, drop mem_req and go to RESP with err=1 and rdata=0.
- RESP (exactly one cycle):
  - Owner's ready=1.
  - IF: if_rdata = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - D: d_rdata = full doubleword; stores return rdata=0.
  - Requests are ignored this cycle; next state is IDLE.
- Requesters drop or renew req the cycle after ready. Minimum latency: req seen in cycle 0, mem_req in cycle 1, ack in cycle 1, ready in cycle 2, next grant sampled in cycle 3.
- mem_ack outside ISSUE is ignored, including a late ack after a timeout or after reset.
- Reset mid-access: the state goes to IDLE at the reset edge and mem_req drops. No ready pulse is produced for the aborted access.
- Never: ready pulsed to the non-owner, or both readies in one cycle.
- Address/data changes by a requester during an access are invisible, because all fields are latched at grant.

Test Plan:
- Single load: d_req, d_addr=0x40, we=0; memory acks 1 cycle after mem_req with 64'h1122334455667788 -> mem_addr=0x40, mem_wmask=0; d_ready pulses once with d_rdata=64'h1122334455667788, err=0.
- Fetch word select: if_addr=0x104, mem_rdata=64'hAAAABBBB_CCCCDDDD -> mem_addr=0x100, if_rdata=32'hAAAABBBB; a repeat at 0x100 gives 32'hCCCCDDDD.
- Contention/fairness: d_req and if_req held continuously, MAX_D_GRANTS=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; IF is never starved.
- SW store: d_we=1, d_wmask=8'h0F, d_wdata=64'h0000_0000_DEADBEEF -> mem_we=1 with mask 8'h0F and data passed through; zero-mask store completes in 2 cycles with no mem_req.
- Timeout: mem_ack held low, TIMEOUT=16 -> mem_req high for 16 cycles then drops; d_ready=1, d_err=1, d_rdata=0; a late mem_ack is ignored.
- Reset mid-ISSUE: rst asserted during an outstanding fetch -> next cycle mem_req=0, no if_ready; a request after reset is granted normally.
